// File: rtl/tt_sweep.sv
// tt_sweep: drives all 8 {a,b,c} vectors into a 3-input block,
// captures its truth table and compares it against a golden table.
module tt_sweep #(
   parameter int unsigned HOLD   = 10,
   parameter logic [7:0]  EXPECT = 8'hE8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       z_in,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic [7:0] tt,
   output logic       err,
   output logic [3:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] hold_q, hold_d;
   logic [2:0] abc_q, abc_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [7:0] tt_q, tt_d;
   logic [3:0] err_cnt_q, err_cnt_d;

   logic last_c;
   logic miss_c;

   assign last_c = (hold_q == HOLD_LAST);
   assign miss_c = (z_in != EXPECT[idx_q]);

   // Next-state, capture and registered-output computation
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      hold_d    = hold_q;
      tt_d      = tt_q;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               idx_d     = 3'd0;
               hold_d    = 8'd0;
               tt_d      = 8'h00;
               err_d     = 1'b0;
               err_cnt_d = 4'd0;
            end
         end
         RUN: begin
            hold_d = hold_q + 8'd1;
            if (last_c) begin
               tt_d[idx_q] = z_in;
               if (miss_c) begin
                  err_cnt_d = err_cnt_q + 4'd1;
               end
               hold_d = 8'd0;
               if (idx_q != 3'd7) begin
                  idx_d = idx_q + 3'd1;
               end else begin
                  // Last vector ends the sweep; idx never wraps
                  state_d = FIN;
                  idx_d   = 3'd0;
                  err_d   = (err_cnt_d != 4'd0);
               end
            end
         end
         FIN: begin
            state_d = IDLE;
            err_d   = (err_cnt_q != 4'd0);
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == FIN);
      abc_d  = (state_d == RUN) ? idx_d : 3'b000;
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= 3'd0;
         hold_q    <= 8'd0;
         abc_q     <= 3'b000;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         tt_q      <= 8'h00;
         err_q     <= 1'b0;
         err_cnt_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         hold_q    <= hold_d;
         abc_q     <= abc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         tt_q      <= tt_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign a       = abc_q[2];
   assign b       = abc_q[1];
   assign c       = abc_q[0];
   assign busy    = busy_q;
   assign done    = done_q;
   assign tt      = tt_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;

endmodule
